// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared state encoding and pattern defaults for the pattern scan controller
package pattern_scan_pkg;
  localparam int PAT_W = 3;
  localparam logic [PAT_W-1:0] PAT_RST_DEF = 3'b101;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_pattern_fsm.sv
// serial_pattern_fsm: overlapping Mealy 3-bit pattern detector with a two-bit history
module serial_pattern_fsm
  import pattern_scan_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);
  logic [1:0] hist;
  logic [1:0] len;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      len  <= '0;
    end else if (clr) begin
      hist <= '0;
      len  <= '0;
    end else if (en) begin
      hist <= {hist[0], bit_i};
      len  <= (len == 2'd2) ? len : len + 2'd1;
    end
  end
  // hist[1] is the oldest bit, matching pattern bit 2 as the first serial bit
  assign match = en & (len == 2'd2) & ({hist, bit_i} == pattern);
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: feeds a handshaked parallel word LSB-first into the serial detector and returns the match count
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_RST_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready,
  output logic             busy,
  output logic             match_o
);
  localparam int IDX_W = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic [PAT_W-1:0] pattern;
  logic accept, last;
  assign accept = (state == IDLE) & in_valid;
  assign last   = idx == IDX_W'(WIDTH - 1);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE)  ? (in_valid  ? SHIFT : IDLE)  :
               (state == SHIFT) ? (last      ? DONE  : SHIFT) :
               (state == DONE)  ? (out_ready ? IDLE  : DONE)  : IDLE;
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = (state == SHIFT) | (state == DONE);
    out_count = count;
  end
  // a pattern written on the accepting edge is already in place for the first serial bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      idx     <= '0;
      count   <= '0;
      pattern <= PAT_RST;
    end else begin
      if ((state == IDLE) && cfg_we) pattern <= cfg_pattern;
      if (accept) begin
        shreg <= in_data;
        idx   <= '0;
        count <= '0;
      end else if (state == SHIFT) begin
        shreg <= shreg >> 1;
        idx   <= idx + 1'b1;
        count <= count + CNT_W'(match_o);
      end
    end
  end
  serial_pattern_fsm u_det (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (state == SHIFT),
    .bit_i   (shreg[0]),
    .pattern (pattern),
    .match   (match_o)
  );
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed scoreboard bench for the pattern scan controller
module tb_pattern_scan_ctrl;
  logic       clock = 0, reset_n = 0, cfg_we = 0, in_valid = 0, out_ready = 1;
  logic [2:0] cfg_pattern = '0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, busy, match_o;
  logic [3:0] out_count;
  int total = 0, bad = 0;
  int q[$];

  pattern_scan_ctrl dut (
    .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_count(out_count), .out_ready(out_ready), .busy(busy), .match_o(match_o)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(logic [7:0] data, bit push, int exp);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1;
    in_data  = data;
    if (push) q.push_back(exp);
    tick();
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("out_count", 32'(out_count), 32'(q.pop_front()));
    end
  end

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_match", match_o, 0);
    tick();
    tick();
    reset_n = 1;
    tick();
    // default pattern 101 on 0x55: pulses on serial bits 2, 4, 6
    send(8'h55, 1, 3);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("match_bit%0d", i), match_o, (i == 2 || i == 4 || i == 6) ? 1 : 0);
      chk("shift_busy", busy, 1);
      tick();
    end
    chk("latency_out_valid", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    tick();
    chk("back_to_idle", in_ready, 1);
    // pattern write on the accepting edge applies to that word
    cfg_we = 1;
    cfg_pattern = 3'b111;
    send(8'hFF, 1, 6);
    cfg_we = 0;
    wait_idle();
    cfg_we = 1;
    cfg_pattern = 3'b101;
    send(8'h00, 1, 0);
    cfg_we = 0;
    wait_idle();
    // write during SHIFT must be ignored
    cfg_we = 1;
    cfg_pattern = 3'b110;
    tick();
    cfg_we = 0;
    send(8'h03, 1, 1);
    tick();
    tick();
    cfg_we = 1;
    cfg_pattern = 3'b000;
    tick();
    cfg_we = 0;
    wait_idle();
    send(8'h03, 1, 1);
    wait_idle();
    // consumer stall in DONE
    cfg_we = 1;
    cfg_pattern = 3'b101;
    out_ready = 0;
    send(8'h55, 1, 3);
    cfg_we = 0;
    repeat (8) tick();
    in_valid = 1;
    in_data = 8'hAA;
    q.push_back(3);
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_count", out_count, 3);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1;
    tick();
    chk("stall_released_idle", in_ready, 1);
    tick();
    in_valid = 0;
    chk("stall_word_accepted", busy, 1);
    wait_idle();
    // back to back; history must not carry across words
    send(8'h55, 1, 3);
    send(8'hAA, 1, 3);
    wait_idle();
    send(8'h55, 1, 3);
    send(8'h01, 1, 0);
    wait_idle();
    // asynchronous reset mid-word restores pattern 101 and drops the word
    cfg_we = 1;
    cfg_pattern = 3'b111;
    tick();
    cfg_we = 0;
    send(8'h55, 0, 0);
    repeat (4) tick();
    reset_n = 0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_count", out_count, 0);
    chk("arst_match", match_o, 0);
    tick();
    reset_n = 1;
    repeat (12) tick();
    send(8'h55, 1, 3);
    wait_idle();
    tick();
    tick();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
